mc_ctrl_seq: RTL and testbench
==============================

Name: mc_ctrl_seq

Overview:
- Multi-cycle control sequencer for the team CPU datapath; sits directly upstream of the 4-to-1 select muxes.
- Generates the 2-bit writeback-source select (wb_sel) and PC-source select (pc_sel) those muxes consume, plus register/memory/ALU enables.
- Walks each instruction through IF/ID/EX/MEM/WB, stalling on memory handshakes.

Parameters:
- OPW, 4, opcode width.
- ALUOPW, 3, ALU operation code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPW  opcode field of the instruction register; valid from ID onward.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- flag_z  in  1  registered ALU zero flag.
- flag_n  in  1  registered ALU negative flag.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_sel  out  2  PC mux select: 00 PC+1, 01 rs (jump/branch), 10 dmem data (JM), 11 hold.
- wb_sel  out  2  writeback mux select: 00 ALU, 01 dmem, 10 PC+imm, 11 zero.
- reg_we  out  1  register file write enable.
- dmem_re  out  1  data memory read request.
- dmem_we  out  1  data memory write request.
- alu_op  out  ALUOPW  000 pass, 001 add, 010 inc, 011 neg, 100 sub.
- flag_we  out  1  capture ALU flags.
- busy  out  1  high in every state except IF.

Behaviour:
- States: IF, ID, EX, MEM, WB. Outputs are Moore, decoded from the state and the latched opcode.
- Reset: state IF. All enables 0, pc_sel 11, wb_sel 00, alu_op 000, busy 0. rst mid-instruction aborts it, with no partial write after the reset edge.
- IF: ir_we = imem_ready, pc_we = imem_ready, pc_sel 00. Advance to ID only on imem_ready; otherwise hold with all writes 0.
- ID: opcode latched internally.
  - NOP (0000) -> IF.
  - SVPC (1111) -> WB.
  - All others -> EX.
- EX:
  - ADD (0100), INC (0101), NEG (0110), SUB (0111): alu_op set, flag_we 1 -> WB.
  - LD (1110), ST (0011), JM (1010): alu_op pass (address) -> MEM.
  - J (1000): pc_we 1, pc_sel 01 -> IF.
  - BRZ (1001): pc_we = flag_z, pc_sel 01 -> IF.
  - BRN (1011): pc_we = flag_n, pc_sel 01 -> IF.
  - Undefined opcodes: treated as NOP -> IF.
- MEM: LD/JM drive dmem_re, ST drives dmem_we; each is held until dmem_ready.
  - On dmem_ready: LD -> WB; ST -> IF; JM asserts pc_we with pc_sel 10 -> IF.
- WB: reg_we 1, single cycle -> IF.
  - wb_sel 00 for ALU ops, 01 for LD, 10 for SVPC.
- Latency with zero wait states, in cycles:
  - NOP: 2.
  - J, BRZ, BRN, SVPC: 3.
  - ALU ops, ST, JM: 4.
  - LD: 5.
  - Each stall cycle adds 1.
- Invariants:
  - reg_we, dmem_we and pc_we are never high in the same cycle as each other, except pc_we with ir_we in IF.
  - Flags are sampled in the EX cycle only.

Optional Feature:
- Macro: MC_CTRL_RETIRE_CNT_EN.
- Defined: extra output retire_cnt (32 bits).
  - Increments on the last cycle of each instruction, i.e. the cycle whose next state is IF.
  - Stall cycles do not count. Wraps from 0xFFFFFFFF to 0. Cleared by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg: opcode constants, state encoding, pc_sel/wb_sel/alu_op encodings.
- One sub-module, mc_ctrl_decode: combinational map from opcode to class (alu, load, store, jump, branch_z, branch_n, jm, svpc, nop) and alu_op.

Test Plan:
- rst high 2 cycles mid-EX of ADD -> next cycle state IF, reg_we 0, pc_sel 11, busy 0.
- ADD (0100), both readys 1 -> ir_we at cycle 0; flag_we + alu_op 001 at cycle 2; reg_we + wb_sel 00 at cycle 3; back to IF at cycle 4.
- LD with dmem_ready low 3 cycles -> dmem_re high 4 cycles, then WB with wb_sel 01, reg_we 1; 8 cycles total.
- BRZ with flag_z 0, then repeated with flag_z 1 -> pc_we 0 and pc_we 1 (pc_sel 01) respectively in EX; 3 cycles each.
- JM with dmem_ready 1 -> MEM cycle has dmem_re 1, pc_we 1, pc_sel 10; reg_we never asserted.
- With MC_CTRL_RETIRE_CNT_EN: run NOP, ST, SVPC -> retire_cnt = 3; imem_ready low 5 cycles leaves it unchanged.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, FSM states,
// instruction classes and the mux-select / ALU-op codes driven downstream.
package mc_ctrl_pkg;

  localparam int OPW_D    = 4;
  localparam int ALUOPW_D = 3;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP   = 4'd0,
    CL_ALU   = 4'd1,
    CL_LOAD  = 4'd2,
    CL_STORE = 4'd3,
    CL_JUMP  = 4'd4,
    CL_BRZ   = 4'd5,
    CL_BRN   = 4'd6,
    CL_JM    = 4'd7,
    CL_SVPC  = 4'd8
  } iclass_t;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_RS   = 2'b01;
  localparam logic [1:0] PC_DMEM = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_DMEM  = 2'b01;
  localparam logic [1:0] WB_PCIMM = 2'b10;
  localparam logic [1:0] WB_ZERO  = 2'b11;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_INC  = 3'b010;
  localparam logic [2:0] ALU_NEG  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode classifier; undefined opcodes fall into the NOP class.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPW    = OPW_D,
  parameter int ALUOPW = ALUOPW_D
) (
  input  logic [OPW-1:0]    opcode,
  output iclass_t           iclass,
  output logic [ALUOPW-1:0] alu_op
);

  // opcode -> instruction class and ALU operation
  always_comb begin
    iclass = CL_NOP;
    alu_op = ALU_PASS;
    case (opcode)
      OP_ADD:  begin iclass = CL_ALU; alu_op = ALU_ADD; end
      OP_INC:  begin iclass = CL_ALU; alu_op = ALU_INC; end
      OP_NEG:  begin iclass = CL_ALU; alu_op = ALU_NEG; end
      OP_SUB:  begin iclass = CL_ALU; alu_op = ALU_SUB; end
      OP_LD:   iclass = CL_LOAD;
      OP_ST:   iclass = CL_STORE;
      OP_JM:   iclass = CL_JM;
      OP_J:    iclass = CL_JUMP;
      OP_BRZ:  iclass = CL_BRZ;
      OP_BRN:  iclass = CL_BRN;
      OP_SVPC: iclass = CL_SVPC;
      default: iclass = CL_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_seq.sv
// IF/ID/EX/MEM/WB control sequencer feeding the PC and writeback select muxes.
// Optional retire counter output enabled by defining MC_CTRL_RETIRE_CNT_EN.
module mc_ctrl_seq
  import mc_ctrl_pkg::*;
#(
  parameter int OPW    = OPW_D,
  parameter int ALUOPW = ALUOPW_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              flag_z,
  input  logic              flag_n,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [1:0]        wb_sel,
  output logic              reg_we,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [ALUOPW-1:0] alu_op,
  output logic              flag_we,
  output logic              busy
`ifdef MC_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  state_t            state_r;
  state_t            state_nxt;
  logic [OPW-1:0]    op_r;
  logic [OPW-1:0]    dec_op;
  iclass_t           iclass;
  logic [ALUOPW-1:0] dec_alu_op;

  // ID still sees the live opcode; later states use the copy taken in ID
  assign dec_op = (state_r == ST_ID) ? opcode : op_r;

  mc_ctrl_decode #(.OPW(OPW), .ALUOPW(ALUOPW)) u_decode (
    .opcode (dec_op),
    .iclass (iclass),
    .alu_op (dec_alu_op)
  );

  // state register and opcode latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IF;
      op_r    <= {OPW{1'b0}};
    end else begin
      state_r <= state_nxt;
      if (state_r == ST_ID) op_r <= opcode;
    end
  end

  // next-state selection
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IF:  state_nxt = imem_ready ? ST_ID : ST_IF;
      ST_ID: begin
        if (dec_op == OP_NOP)       state_nxt = ST_IF;
        else if (dec_op == OP_SVPC) state_nxt = ST_WB;
        else                        state_nxt = ST_EX;
      end
      ST_EX: begin
        case (iclass)
          CL_ALU:                     state_nxt = ST_WB;
          CL_LOAD, CL_STORE, CL_JM:   state_nxt = ST_MEM;
          default:                    state_nxt = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (!dmem_ready)             state_nxt = ST_MEM;
        else if (iclass == CL_LOAD)  state_nxt = ST_WB;
        else                         state_nxt = ST_IF;
      end
      ST_WB:   state_nxt = ST_IF;
      default: state_nxt = ST_IF;
    endcase
  end

  // Moore output decode; rst forces the idle vector so an aborted instruction writes nothing
  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = PC_HOLD;
    wb_sel  = WB_ALU;
    reg_we  = 1'b0;
    dmem_re = 1'b0;
    dmem_we = 1'b0;
    alu_op  = ALU_PASS;
    flag_we = 1'b0;
    busy    = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else begin
      busy = (state_r != ST_IF);
      case (state_r)
        ST_IF: begin
          ir_we  = imem_ready;
          pc_we  = imem_ready;
          pc_sel = imem_ready ? PC_INC : PC_HOLD;
        end
        ST_ID: busy = 1'b1;
        ST_EX: begin
          case (iclass)
            CL_ALU:  begin alu_op = dec_alu_op; flag_we = 1'b1; end
            CL_JUMP: begin pc_we = 1'b1;   pc_sel = PC_RS; end
            CL_BRZ:  begin pc_we = flag_z; pc_sel = PC_RS; end
            CL_BRN:  begin pc_we = flag_n; pc_sel = PC_RS; end
            default: alu_op = ALU_PASS;
          endcase
        end
        ST_MEM: begin
          case (iclass)
            CL_LOAD:  dmem_re = 1'b1;
            CL_STORE: dmem_we = 1'b1;
            CL_JM: begin
              dmem_re = 1'b1;
              pc_we   = dmem_ready;
              pc_sel  = dmem_ready ? PC_DMEM : PC_HOLD;
            end
            default: dmem_re = 1'b0;
          endcase
        end
        ST_WB: begin
          reg_we = 1'b1;
          case (iclass)
            CL_LOAD: wb_sel = WB_DMEM;
            CL_SVPC: wb_sel = WB_PCIMM;
            default: wb_sel = WB_ALU;
          endcase
        end
        default: busy = 1'b0;
      endcase
    end
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  // count instructions on their final cycle; IF stalls never qualify
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= 32'd0;
    end else if ((state_r != ST_IF) && (state_nxt == ST_IF)) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Randomized scoreboard bench for mc_ctrl_seq: per-instruction cycle plans are
// built from the opcode rules and checked by an independent negedge monitor.
module tb_mc_ctrl_seq;

  localparam logic [3:0] T_NOP = 4'b0000, T_ST = 4'b0011, T_ADD = 4'b0100,
                         T_INC = 4'b0101, T_NEG = 4'b0110, T_SUB = 4'b0111,
                         T_J = 4'b1000, T_BRZ = 4'b1001, T_JM = 4'b1010,
                         T_BRN = 4'b1011, T_LD = 4'b1110, T_SVPC = 4'b1111;

  logic       clk = 1'b0;
  logic       rst, imem_ready, dmem_ready, flag_z, flag_n;
  logic [3:0] opcode;
  logic       ir_we, pc_we, reg_we, dmem_re, dmem_we, flag_we, busy;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] alu_op;
`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int total = 0;
  int bad = 0;
  int retired = 0;
  logic [13:0] exp_q[$];
  string       tag_q[$];
  logic [13:0] act;

  always #5 clk = ~clk;

  mc_ctrl_seq dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .flag_z(flag_z), .flag_n(flag_n),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .wb_sel(wb_sel),
    .reg_we(reg_we), .dmem_re(dmem_re), .dmem_we(dmem_we), .alu_op(alu_op),
    .flag_we(flag_we), .busy(busy)
`ifdef MC_CTRL_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  // output order: ir_we pc_we pc_sel wb_sel reg_we dmem_re dmem_we alu_op flag_we busy
  assign act = {ir_we, pc_we, pc_sel, wb_sel, reg_we, dmem_re, dmem_we, alu_op, flag_we, busy};

  function automatic logic [13:0] ov(logic ir, logic pw, logic [1:0] ps, logic [1:0] ws,
                                     logic rw, logic re, logic we, logic [2:0] ao,
                                     logic fw, logic bz);
    return {ir, pw, ps, ws, rw, re, we, ao, fw, bz};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  // monitor: one expected output vector per cycle
  always @(negedge clk) begin
    logic [13:0] e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: outputs got %b expected %b", t, act, e);
      end
    end
  end

  task automatic step(input logic r, input logic im, input logic dm, input logic fz,
                      input logic fn, input logic [3:0] op, input logic [13:0] e,
                      input string t);
    @(posedge clk);
    #1;
    rst = r; imem_ready = im; dmem_ready = dm; flag_z = fz; flag_n = fn; opcode = op;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic idle(input string t);
    step(1'b0, 1'b0, rb(), rb(), rb(), rop(), ov(1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0), t);
  endtask

  task automatic chk_retire(input string t);
`ifdef MC_CTRL_RETIRE_CNT_EN
    total++;
    if (retire_cnt !== 32'(retired)) begin
      bad++;
      $display("FAIL %s: retire_cnt got %0d expected %0d", t, retire_cnt, retired);
    end
`else
    if (t.len() < 0) $display("%s", t);
`endif
  endtask

  // expected cycle plan of one instruction, given IF and MEM stall counts
  task automatic run_instr(input logic [3:0] op, input logic fz, input logic fn,
                           input int ki, input int kd, input string t);
    logic [13:0] in_flight;
    logic [13:0] mem_v;
    in_flight = ov(1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < ki; i++) idle({t, "_ifwait"});
    step(1'b0, 1'b1, rb(), rb(), rb(), rop(),
         ov(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0), {t, "_if"});
    step(1'b0, rb(), rb(), rb(), rb(), op, in_flight, {t, "_id"});
    case (op)
      T_NOP: ;
      T_SVPC: step(1'b0, rb(), rb(), rb(), rb(), op,
                   ov(1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1), {t, "_wb"});
      T_ADD, T_INC, T_NEG, T_SUB: begin
        step(1'b0, rb(), rb(), rb(), rb(), op,
             ov(1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 3'(op[1:0]) + 3'd1, 1'b1, 1'b1), {t, "_ex"});
        step(1'b0, rb(), rb(), rb(), rb(), op,
             ov(1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1), {t, "_wb"});
      end
      T_J:   step(1'b0, rb(), rb(), rb(), rb(), op,
                  ov(1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1), {t, "_ex"});
      T_BRZ: step(1'b0, rb(), rb(), fz, rb(), op,
                  ov(1'b0, fz, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1), {t, "_ex"});
      T_BRN: step(1'b0, rb(), rb(), rb(), fn, op,
                  ov(1'b0, fn, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1), {t, "_ex"});
      T_LD, T_ST, T_JM: begin
        step(1'b0, rb(), rb(), rb(), rb(), op, in_flight, {t, "_ex"});
        mem_v = ov(1'b0, 1'b0, 2'b11, 2'b00, 1'b0, op != T_ST, op == T_ST, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < kd; i++) step(1'b0, rb(), 1'b0, rb(), rb(), op, mem_v, {t, "_memwait"});
        if (op == T_JM) mem_v = ov(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
        step(1'b0, rb(), 1'b1, rb(), rb(), op, mem_v, {t, "_mem"});
        if (op == T_LD)
          step(1'b0, rb(), rb(), rb(), rb(), op,
               ov(1'b0, 1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1), {t, "_wb"});
      end
      default: step(1'b0, rb(), rb(), rb(), rb(), op, in_flight, {t, "_ex_undef"});
    endcase
    retired++;
  endtask

  initial begin
    logic [13:0] rst_v;
    rst_v = ov(1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; flag_z = 1'b0; flag_n = 1'b0; opcode = 4'b0000;

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, T_ADD, rst_v, "reset0");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, T_ADD, rst_v, "reset1");

    // ADD aborted by a two-cycle reset while in EX
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rop(),
         ov(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0), "abort_if");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, T_ADD,
         ov(1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1), "abort_id");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, T_ADD, rst_v, "abort_ex_rst");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, T_ADD, rst_v, "abort_rst2");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, T_ADD, rst_v, "abort_after");
    chk_retire("retire_after_reset");

    run_instr(T_ADD, 1'b0, 1'b0, 0, 0, "add");
    run_instr(T_LD,  1'b0, 1'b0, 0, 3, "ld_stall3");
    run_instr(T_BRZ, 1'b0, 1'b0, 0, 0, "brz_z0");
    run_instr(T_BRZ, 1'b1, 1'b0, 0, 0, "brz_z1");
    run_instr(T_BRN, 1'b0, 1'b1, 0, 0, "brn_n1");
    run_instr(T_JM,  1'b0, 1'b0, 0, 0, "jm");
    run_instr(T_ST,  1'b0, 1'b0, 1, 2, "st_stall");
    run_instr(4'b1100, 1'b0, 1'b0, 0, 0, "undef");
    idle("gap");
    chk_retire("retire_directed");

    run_instr(T_NOP,  1'b0, 1'b0, 0, 0, "nop");
    run_instr(T_ST,   1'b0, 1'b0, 0, 0, "st");
    run_instr(T_SVPC, 1'b0, 1'b0, 0, 0, "svpc");
    idle("gap2");
    chk_retire("retire_nop_st_svpc");
    for (int i = 0; i < 5; i++) idle("imem_idle");
    chk_retire("retire_after_idle");

    for (int n = 0; n < 200; n++)
      run_instr(rop(), rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 3), "rand");
    idle("tail");
    chk_retire("retire_random");

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
